// File: rtl/tri_check_sched_if.sv
// tri_check_sched_if
// Groups every handshake signal around the scheduler: both requester ports,
// the serial link to the triangle-checker core and the busy flag.
//   req0/req1       request, held with stable sides until ack
//   sides0/sides1   {a,b,c}, 3 bits each, a in [8:6]
//   ack0/ack1       one-cycle pulse, request latched
//   done0/done1     one-cycle pulse, res/err valid
//   res0/res1       checker verdict, 0 outside done
//   err0/err1       timeout flag, 0 outside done
//   c_in_valid      side strobe to the checker
//   c_input         side value to the checker, 0 when not strobed
//   c_out           checker verdict
//   c_out_valid     checker verdict strobe
//   busy            scheduler not idle
// The slave modport is the scheduler's view; the master modport is the
// surrounding environment (requesters plus checker core).
interface tri_check_sched_if;
  logic       req0;
  logic       req1;
  logic [8:0] sides0;
  logic [8:0] sides1;
  logic       ack0;
  logic       ack1;
  logic       done0;
  logic       done1;
  logic       res0;
  logic       res1;
  logic       err0;
  logic       err1;
  logic       c_in_valid;
  logic [2:0] c_input;
  logic       c_out;
  logic       c_out_valid;
  logic       busy;

  modport slave (
    input  req0, req1, sides0, sides1, c_out, c_out_valid,
    output ack0, ack1, done0, done1, res0, res1, err0, err1,
           c_in_valid, c_input, busy
  );

  modport master (
    output req0, req1, sides0, sides1, c_out, c_out_valid,
    input  ack0, ack1, done0, done1, res0, res1, err0, err1,
           c_in_valid, c_input, busy
  );
endinterface

// File: rtl/tri_check_sched.sv
// tri_check_sched
// Round-robin scheduler sharing one serial triangle-checker between two
// requesters. A granted request has its three sides latched, streamed to the
// checker one per cycle, and the checker verdict (or a timeout error) is
// returned to the granted requester as a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any transaction in flight
//   bus    tri_check_sched_if.slave (requesters, checker link, busy)
// Parameter:
//   TIMEOUT  WAIT cycles without a checker response before aborting (1..255)
module tri_check_sched #(
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  tri_check_sched_if.slave bus
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t     state_r, state_s;
  logic       last_r, last_s;
  logic       winner_r, winner_s;
  logic [8:0] sides_r, sides_s;
  logic [1:0] side_cnt_r, side_cnt_s;
  logic [7:0] timer_r, timer_s;
  logic [7:0] timer_inc_s;

  logic       pick_s;
  logic [8:0] pick_sides_s;
  logic       deliver_s;
  logic       verdict_s;
  logic       fault_s;

  logic       ack0_r, ack0_s;
  logic       ack1_r, ack1_s;
  logic       done0_r, done0_s;
  logic       done1_r, done1_s;
  logic       res0_r, res0_s;
  logic       res1_r, res1_s;
  logic       err0_r, err0_s;
  logic       err1_r, err1_s;
  logic       c_in_valid_r, c_in_valid_s;
  logic [2:0] c_input_r, c_input_s;
  logic       busy_r, busy_s;

  // Round-robin choice among the requests raised this cycle
  always_comb begin
    pick_s       = 1'b0;
    pick_sides_s = bus.sides0;
    // With both raised, the one not served last time wins
    if (bus.req0 && bus.req1) begin
      pick_s = ~last_r;
    end else if (bus.req1) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    if (pick_s) begin
      pick_sides_s = bus.sides1;
    end else begin
      pick_sides_s = bus.sides0;
    end
  end

  // Next-state and next-output logic of the transaction FSM
  always_comb begin
    state_s      = state_r;
    last_s       = last_r;
    winner_s     = winner_r;
    sides_s      = sides_r;
    side_cnt_s   = side_cnt_r;
    timer_s      = timer_r;
    timer_inc_s  = timer_r + 8'd1;
    ack0_s       = 1'b0;
    ack1_s       = 1'b0;
    c_in_valid_s = 1'b0;
    c_input_s    = 3'd0;
    deliver_s    = 1'b0;
    verdict_s    = 1'b0;
    fault_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_s     = pick_s;
          last_s       = pick_s;
          sides_s      = pick_sides_s;
          side_cnt_s   = 2'd0;
          ack0_s       = ~pick_s;
          ack1_s       = pick_s;
          // Side a goes out together with the ack, straight from the port
          c_in_valid_s = 1'b1;
          c_input_s    = pick_sides_s[8:6];
          state_s      = ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        // Counter 0/1 schedule sides b/c; counter 2 closes the burst
        case (side_cnt_r)
          2'd0: begin
            c_in_valid_s = 1'b1;
            c_input_s    = sides_r[5:3];
            side_cnt_s   = 2'd1;
          end
          2'd1: begin
            c_in_valid_s = 1'b1;
            c_input_s    = sides_r[2:0];
            side_cnt_s   = 2'd2;
          end
          default: begin
            side_cnt_s = 2'd0;
            timer_s    = 8'd0;
            state_s    = ST_WAIT;
          end
        endcase
      end

      ST_WAIT: begin
        if (bus.c_out_valid) begin
          deliver_s = 1'b1;
          verdict_s = bus.c_out;
          timer_s   = 8'd0;
          state_s   = ST_RESP;
        end else if (timer_inc_s == TIMEOUT_C) begin
          deliver_s = 1'b1;
          fault_s   = 1'b1;
          timer_s   = 8'd0;
          state_s   = ST_RESP;
        end else begin
          timer_s = timer_inc_s;
        end
      end

      ST_RESP: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s    = ST_IDLE;
        side_cnt_s = 2'd0;
        timer_s    = 8'd0;
      end
    endcase

    // The verdict is steered only to the requester that owns the transaction
    done0_s = deliver_s & ~winner_r;
    done1_s = deliver_s & winner_r;
    res0_s  = deliver_s & ~winner_r & verdict_s;
    res1_s  = deliver_s & winner_r & verdict_s;
    err0_s  = deliver_s & ~winner_r & fault_s;
    err1_s  = deliver_s & winner_r & fault_s;
    busy_s  = (state_s != ST_IDLE);
  end

  // FSM state, arbitration pointer, latched request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_r       <= 1'b1;
      winner_r     <= 1'b0;
      sides_r      <= 9'd0;
      side_cnt_r   <= 2'd0;
      timer_r      <= 8'd0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      done0_r      <= 1'b0;
      done1_r      <= 1'b0;
      res0_r       <= 1'b0;
      res1_r       <= 1'b0;
      err0_r       <= 1'b0;
      err1_r       <= 1'b0;
      c_in_valid_r <= 1'b0;
      c_input_r    <= 3'd0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_r       <= last_s;
      winner_r     <= winner_s;
      sides_r      <= sides_s;
      side_cnt_r   <= side_cnt_s;
      timer_r      <= timer_s;
      ack0_r       <= ack0_s;
      ack1_r       <= ack1_s;
      done0_r      <= done0_s;
      done1_r      <= done1_s;
      res0_r       <= res0_s;
      res1_r       <= res1_s;
      err0_r       <= err0_s;
      err1_r       <= err1_s;
      c_in_valid_r <= c_in_valid_s;
      c_input_r    <= c_input_s;
      busy_r       <= busy_s;
    end
  end

  assign bus.ack0       = ack0_r;
  assign bus.ack1       = ack1_r;
  assign bus.done0      = done0_r;
  assign bus.done1      = done1_r;
  assign bus.res0       = res0_r;
  assign bus.res1       = res1_r;
  assign bus.err0       = err0_r;
  assign bus.err1       = err1_r;
  assign bus.c_in_valid = c_in_valid_r;
  assign bus.c_input    = c_input_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_tri_check_sched.sv
// tb_tri_check_sched
// Directed bench for tri_check_sched. Stimulus pushes the expected ack ids,
// side stream and done responses into queues; a negedge monitor pops and
// compares whenever the DUT shows ack, c_in_valid or done. A small checker
// responder plays back hand-chosen verdicts with a given delay.
module tb_tri_check_sched;

  typedef struct { int id; int gap; } ack_t;
  typedef struct { int id; int res; int err; int lat; } done_t;
  typedef struct { int delay; int val; int silent; int spur; } rsp_t;

  logic clk = 1'b0;
  logic rst_n;

  ack_t  exp_ack_q[$];
  int    exp_side_q[$];
  done_t exp_done_q[$];
  rsp_t  rsp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int last_done_cyc = -1000;

  tri_check_sched_if bus ();

  tri_check_sched #(.TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    logic [12:0] v;
    v = {bus.ack0, bus.ack1, bus.done0, bus.done1, bus.res0, bus.res1,
         bus.err0, bus.err1, bus.c_in_valid, bus.c_input, bus.busy};
    chk({name, "_known"}, int'($isunknown(v)), 0);
    chk(name, int'(v), 0);
  endtask

  task automatic push_rsp(input int delay, input int val, input int silent, input int spur);
    rsp_t r;
    r.delay = delay; r.val = val; r.silent = silent; r.spur = spur;
    rsp_q.push_back(r);
  endtask

  task automatic push_txn(input int id, input logic [8:0] sides, input int gap,
                          input int res, input int err, input int lat);
    ack_t  a;
    done_t d;
    a.id = id; a.gap = gap;
    exp_ack_q.push_back(a);
    exp_side_q.push_back(int'(sides[8:6]));
    exp_side_q.push_back(int'(sides[5:3]));
    exp_side_q.push_back(int'(sides[2:0]));
    d.id = id; d.res = res; d.err = err; d.lat = lat;
    exp_done_q.push_back(d);
  endtask

  task automatic wait_ack(input int id, input string name);
    int n;
    n = 0;
    while (!((id == 0) ? bus.ack0 : bus.ack1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ack_seen"}, int'(n < 60), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_done_q.size() != 0 || bus.busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, int'(n < 300), 1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("reset_outputs");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin : monitor
    ack_t  a;
    done_t d;
    int    s;
    cyc++;
    if (!rst_n) begin
      last_done_cyc = -1000;
    end else begin
      if (bus.ack0 || bus.ack1) begin
        chk("ack_onehot", int'(bus.ack0 & bus.ack1), 0);
        chk("ack_expected", int'(exp_ack_q.size() > 0), 1);
        if (exp_ack_q.size() > 0) begin
          a = exp_ack_q.pop_front();
          chk("ack_id", int'(bus.ack1), a.id);
          if (a.gap >= 0) chk("ack_gap_after_done", cyc - last_done_cyc, a.gap);
        end
        ack_cyc = cyc;
      end
      if (bus.c_in_valid) begin
        chk("side_expected", int'(exp_side_q.size() > 0), 1);
        if (exp_side_q.size() > 0) begin
          s = exp_side_q.pop_front();
          chk("c_input", int'(bus.c_input), s);
        end
        chk("busy_while_sending", int'(bus.busy), 1);
      end else begin
        chk("c_input_quiet", int'(bus.c_input), 0);
      end
      if (bus.done0 || bus.done1) begin
        chk("done_onehot", int'(bus.done0 & bus.done1), 0);
        chk("done_expected", int'(exp_done_q.size() > 0), 1);
        if (exp_done_q.size() > 0) begin
          d = exp_done_q.pop_front();
          chk("done_id", int'(bus.done1), d.id);
          chk("res", int'(bus.done1 ? bus.res1 : bus.res0), d.res);
          chk("err", int'(bus.done1 ? bus.err1 : bus.err0), d.err);
          if (d.lat >= 0) chk("done_latency", cyc - ack_cyc, d.lat);
        end
        last_done_cyc = cyc;
      end
      if (!bus.done0) chk("res0_err0_quiet", int'({bus.res0, bus.err0}), 0);
      if (!bus.done1) chk("res1_err1_quiet", int'({bus.res1, bus.err1}), 0);
    end
  end

  // Checker-core stand-in: counts sides and replays the queued verdicts
  initial begin : responder
    int   seen;
    rsp_t r;
    bus.c_out_valid = 1'b0;
    bus.c_out       = 1'b0;
    seen = 0;
    forever begin
      @(negedge clk);
      bus.c_out_valid = 1'b0;
      bus.c_out       = 1'b0;
      if (!rst_n) begin
        seen = 0;
      end else if (bus.c_in_valid) begin
        seen++;
        if (seen == 1 && rsp_q.size() > 0 && rsp_q[0].spur != 0) begin
          bus.c_out_valid = 1'b1;
          bus.c_out       = 1'b1;
        end
        if (seen == 3) begin
          seen = 0;
          if (rsp_q.size() > 0) begin
            r = rsp_q.pop_front();
            if (r.silent == 0) begin
              repeat (r.delay) @(negedge clk);
              bus.c_out_valid = 1'b1;
              bus.c_out       = (r.val != 0);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int cnt;
    int n;
    bus.req0   = 1'b0;
    bus.req1   = 1'b0;
    bus.sides0 = 9'd0;
    bus.sides1 = 9'd0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    #2 chk_zero("por_outputs");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // 1: single request, {7,7,7} -> 1, checker answers 3 cycles after side c
    push_rsp(3, 1, 0, 0);
    push_txn(0, 9'o777, -1, 1, 0, 6);
    bus.sides0 = 9'o777;
    bus.req0   = 1'b1;
    wait_ack(0, "t1");
    bus.req0 = 1'b0;
    wait_idle("t1");

    // 2: simultaneous after reset, 0 first {1,2,1}->0, then 1 {3,4,6}->1
    do_reset();
    push_rsp(1, 0, 0, 0);
    push_rsp(1, 1, 0, 0);
    push_txn(0, 9'o121, -1, 0, 0, 4);
    push_txn(1, 9'o346, 2, 1, 0, 4);
    bus.sides0 = 9'o121;
    bus.sides1 = 9'o346;
    bus.req0   = 1'b1;
    bus.req1   = 1'b1;
    wait_ack(0, "t2_r0");
    bus.req0 = 1'b0;
    wait_ack(1, "t2_r1");
    bus.req1 = 1'b0;
    wait_idle("t2");

    // 3: fairness, both held: 0,1,0,1,0,1; {2,3,4}->1, {1,1,5}->0
    for (int k = 0; k < 6; k++) begin
      push_rsp(2, (k % 2 == 0) ? 1 : 0, 0, 0);
      push_txn(k % 2, (k % 2 == 0) ? 9'o234 : 9'o115, (k == 0) ? -1 : 2,
               (k % 2 == 0) ? 1 : 0, 0, 5);
    end
    bus.sides0 = 9'o234;
    bus.sides1 = 9'o115;
    bus.req0   = 1'b1;
    bus.req1   = 1'b1;
    cnt = 0;
    n   = 0;
    while (cnt < 6 && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.ack0 || bus.ack1) cnt++;
    end
    chk("t3_six_grants", cnt, 6);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle("t3");

    // 4: silent checker -> err after 15 WAIT edges, then {3,1,1}->0
    push_rsp(0, 0, 1, 0);
    push_txn(0, 9'o555, -1, 0, 1, 18);
    bus.sides0 = 9'o555;
    bus.req0   = 1'b1;
    wait_ack(0, "t4_to");
    bus.req0 = 1'b0;
    wait_idle("t4_to");
    push_rsp(1, 0, 0, 0);
    push_txn(0, 9'o311, -1, 0, 0, 4);
    bus.sides0 = 9'o311;
    bus.req0   = 1'b1;
    wait_ack(0, "t4_ok");
    bus.req0 = 1'b0;
    wait_idle("t4_ok");

    // 5: reset after side b, request held, full restart {5,4,3}->1
    begin
      ack_t a;
      a.id = 0; a.gap = -1;
      exp_ack_q.push_back(a);
      exp_side_q.push_back(5);
      exp_side_q.push_back(4);
    end
    bus.sides0 = 9'o543;
    bus.req0   = 1'b1;
    wait_ack(0, "t5_first");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("t5_reset_mid_send");
    push_rsp(1, 1, 0, 0);
    push_txn(0, 9'o543, -1, 1, 0, 4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    wait_ack(0, "t5_again");
    bus.req0 = 1'b0;
    wait_idle("t5");

    // 6: spurious response during SEND ignored, real {1,1,3}->0 in WAIT
    push_rsp(2, 0, 0, 1);
    push_txn(1, 9'o113, -1, 0, 0, 5);
    bus.sides1 = 9'o113;
    bus.req1   = 1'b1;
    wait_ack(1, "t6");
    bus.req1 = 1'b0;
    wait_idle("t6");

    chk("queues_empty", exp_ack_q.size() + exp_side_q.size() +
        exp_done_q.size() + rsp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
